cpu_core: RTL

Parametrised single-cycle accumulator CPU with two working registers A/B, a latched status-flag register, conditional branching and a halt state. Instruction memory is external and read combinationally through the imem port pair, so benches and the top-level computer drive it directly. This is the next-generation core for the computer top level, adding width generality, flags, jumps, stall and halt.

---
 rtl/cpu_core_if.sv | 15 +
 rtl/cpu_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_if.sv
// cpu_core_if: instruction-memory port pair between the core and an external,
// combinationally read instruction store.
//   imem_addr  core -> memory  ADDR_W      fetch address (current PC)
//   imem_data  memory -> core  DATA_W+8    instruction word at imem_addr, same cycle
// Modports: master = core side, slave = memory side.
interface cpu_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W+7:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/cpu_core.sv
// cpu_core: single-cycle accumulator CPU with working registers A/B, a latched
// {Z,N,C,V} flag register, conditional jumps, stall and a terminal HALT state.
// Instruction word: [DATA_W+7:DATA_W+1] opcode, [DATA_W] reserved, [DATA_W-1:0] K.
// ADDR_W must not exceed DATA_W (jump targets are taken from K).
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   stall    1 = hold PC, A, B, flags and FSM state
//   imem     instruction fetch port (cpu_core_if.master)
//   reg_a    register A
//   reg_b    register B
//   flags    {Z,N,C,V}
//   alu_out  combinational ALU result of the instruction being fetched
//   halted   1 while in HALT
module cpu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    cpu_core_if.master        imem,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted
);
    localparam int unsigned OP_W = 7;
    localparam int unsigned MSB  = DATA_W - 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    localparam logic [OP_W-1:0] OP_INC_B = 7'h24;
    localparam logic [OP_W-1:0] OP_INC_A = 7'h25;
    localparam logic [OP_W-1:0] OP_CMP_B = 7'h26;
    localparam logic [OP_W-1:0] OP_CMP_K = 7'h27;
    localparam logic [OP_W-1:0] OP_JMP   = 7'h28;
    localparam logic [OP_W-1:0] OP_JEQ   = 7'h29;
    localparam logic [OP_W-1:0] OP_JNE   = 7'h2A;
    localparam logic [OP_W-1:0] OP_JCS   = 7'h2B;
    localparam logic [OP_W-1:0] OP_JLT   = 7'h2C;
    localparam logic [OP_W-1:0] OP_HLT   = 7'h2D;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        flags_q, flags_d;

    // Instruction fields
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] k;
    logic [3:0]        group;
    logic [1:0]        form;
    logic              is_alu, is_unary;
    logic              unused_rsvd;

    assign op          = imem.imem_data[DATA_W+7:DATA_W+1];
    assign k           = imem.imem_data[DATA_W-1:0];
    assign unused_rsvd = imem.imem_data[DATA_W];
    assign group       = op[5:2];
    assign form        = op[1:0];
    assign is_alu      = (op < OP_INC_B);
    assign is_unary    = (group == 4'd5) || (group == 4'd7) || (group == 4'd8);

    // Operand routing: x is the first operand (or unary source), y the second
    logic [DATA_W-1:0] x, y;
    logic              dest_b;

    always_comb begin : operand_sel
        x      = a_q;
        y      = b_q;
        dest_b = 1'b0;
        if (is_alu) begin
            x = form[0] ? b_q : a_q;
            if (is_unary) begin
                y      = '0;
                dest_b = form[1];
            end else begin
                y      = form[1] ? k : (form[0] ? a_q : b_q);
                dest_b = form[0];
            end
        end else begin
            case (op)
                OP_INC_B: begin x = b_q; y = DATA_W'(1); dest_b = 1'b1; end
                OP_INC_A: begin x = a_q; y = DATA_W'(1); end
                OP_CMP_B: begin x = a_q; y = b_q; end
                OP_CMP_K: begin x = a_q; y = k; end
                default:  ;
            endcase
        end
    end

    // Shared adder/subtractor; the sub MSB is the unsigned borrow
    logic [DATA_W:0] add_w, sub_w;
    logic            add_v, sub_v;

    assign add_w = {1'b0, x} + {1'b0, y};
    assign sub_w = {1'b0, x} - {1'b0, y};
    assign add_v = (x[MSB] == y[MSB]) && (add_w[MSB] != x[MSB]);
    assign sub_v = (x[MSB] != y[MSB]) && (sub_w[MSB] != x[MSB]);

    // Execute: result, carry/overflow, write enables, control decisions
    logic [DATA_W-1:0] res;
    logic              res_c, res_v, wr_reg, wr_flags, jump, is_hlt;
    logic [3:0]        flags_new;

    always_comb begin : execute
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        wr_reg   = 1'b0;
        wr_flags = 1'b0;
        jump     = 1'b0;
        is_hlt   = 1'b0;
        if (is_alu) begin
            wr_reg   = 1'b1;
            wr_flags = 1'b1;
            case (group)
                4'd0: res = y;
                4'd1: begin res = add_w[MSB:0]; res_c = add_w[DATA_W]; res_v = add_v; end
                4'd2: begin res = sub_w[MSB:0]; res_c = sub_w[DATA_W]; res_v = sub_v; end
                4'd3: res = x & y;
                4'd4: res = x | y;
                4'd5: res = ~x;
                4'd6: res = x ^ y;
                4'd7: begin res = x << 1; res_c = x[MSB]; end
                4'd8: begin res = x >> 1; res_c = x[0]; end
                default: begin wr_reg = 1'b0; wr_flags = 1'b0; end
            endcase
        end else begin
            case (op)
                OP_INC_B, OP_INC_A: begin
                    res = add_w[MSB:0]; res_c = add_w[DATA_W]; res_v = add_v;
                    wr_reg = 1'b1; wr_flags = 1'b1;
                end
                OP_CMP_B, OP_CMP_K: begin
                    res = sub_w[MSB:0]; res_c = sub_w[DATA_W]; res_v = sub_v;
                    wr_flags = 1'b1;
                end
                OP_JMP:  jump = 1'b1;
                OP_JEQ:  jump = flags_q[3];
                OP_JNE:  jump = ~flags_q[3];
                OP_JCS:  jump = flags_q[1];
                OP_JLT:  jump = flags_q[2] ^ flags_q[0];
                OP_HLT:  is_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    assign flags_new = {(res == '0), res[MSB], res_c, res_v};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM next state: HALT is left only through reset
    always_comb begin : fsm_next
        state_d = state_q;
        if ((state_q == ST_RUN) && !stall && is_hlt) state_d = ST_HALT;
    end

    // FSM outputs
    always_comb begin : fsm_out
        halted = (state_q == ST_HALT);
    end

    // Datapath next state; HLT itself leaves PC on its own address
    always_comb begin : datapath_next
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        if ((state_q == ST_RUN) && !stall && !is_hlt) begin
            pc_d = jump ? ADDR_W'(k) : pc_q + ADDR_W'(1);
            if (wr_reg && !dest_b) a_d = res;
            if (wr_reg && dest_b)  b_d = res;
            if (wr_flags)          flags_d = flags_new;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= 4'b0000;
        end else begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign reg_a          = a_q;
    assign reg_b          = b_q;
    assign flags          = flags_q;
    assign alu_out        = res;
endmodule
